// File: rtl/lcd_pkg.sv
// Shared types, default timing and helpers for the HD44780-style LCD bus writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int DEF_PWR_CYC   = 750000;
  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_EN_CYC    = 25;
  localparam int DEF_HOLD_CYC  = 4;
  localparam int DEF_EXEC_CYC  = 2500;
  localparam int DEF_LONG_CYC  = 100000;

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  localparam int MIN_CNT_W = 20;

  // A zero-length phase would skip its state entirely; treat it as one cycle.
  function automatic int clamp_cyc(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int max_cyc);
    return max2(MIN_CNT_W, $clog2(max_cyc + 1));
  endfunction

  // 8'h03 decodes as return-home on the controller, so it gets the long wait too.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
    return !rs && (dat == CLEAR || dat == HOME || dat == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed phase; parks at zero instead of wrapping.
module lcd_delay_cnt #(
  parameter int           W       = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= RST_VAL;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (!o_zero) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Writes single bytes onto a parallel LCD bus with setup / enable / hold / execution timing.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int PWR_CYC   = DEF_PWR_CYC,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int EXEC_CYC  = DEF_EXEC_CYC,
  parameter int LONG_CYC  = DEF_LONG_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic [7:0] lcd_dat,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int CNT_W = cnt_width(max2(max2(max2(PWR_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                        max2(EXEC_CYC, LONG_CYC)));

  localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(clamp_cyc(PWR_CYC));
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(clamp_cyc(SETUP_CYC));
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(clamp_cyc(EN_CYC));
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(clamp_cyc(HOLD_CYC));
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(clamp_cyc(EXEC_CYC));
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(clamp_cyc(LONG_CYC));

  lcd_state_e       r_state;
  lcd_state_e       w_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_last;
  logic             w_accept;
  logic             r_rs;
  logic [7:0]       r_dat;
  logic             r_en;

  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (L_PWR)
  ) u_delay_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_value    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Each phase is loaded with its length N and leaves on the edge where the count reads 1.
  assign w_last   = (w_cnt == CNT_W'(1)) || w_cnt_zero;
  assign w_accept = (r_state == IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PWRUP;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      PWRUP: if (w_last) w_next = IDLE;
      IDLE: begin
        if (req_valid) begin
          w_next     = SETUP;
          w_load     = 1'b1;
          w_load_val = L_SETUP;
        end
      end
      SETUP: begin
        if (w_last) begin
          w_next     = PULSE;
          w_load     = 1'b1;
          w_load_val = L_EN;
        end
      end
      PULSE: begin
        if (w_last) begin
          w_next     = HOLD;
          w_load     = 1'b1;
          w_load_val = L_HOLD;
        end
      end
      HOLD: begin
        if (w_last) begin
          w_next     = WAIT;
          w_load     = 1'b1;
          w_load_val = is_long_cmd(r_rs, r_dat) ? L_LONG : L_EXEC;
        end
      end
      WAIT: if (w_last) w_next = IDLE;
      default: w_next = PWRUP;
    endcase
  end

  // Enable is decoded from the next state so the pin comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en  <= 1'b0;
      r_rs  <= 1'b0;
      r_dat <= 8'h00;
    end else begin
      r_en <= (w_next == PULSE);
      if (w_accept) begin
        r_rs  <= req_rs;
        r_dat <= req_data;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = !req_ready;
  assign lcd_dat   = r_dat;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = r_en;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: the driver logs accepted writes, the monitor checks the LCD bus.
module tb_lcd_bus_writer;

  localparam int P_PWR   = 20;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 5;
  localparam int P_LONG  = 12;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready;
  logic       busy;
  logic [7:0] lcd_dat;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_acc = 0;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         acc;
  } item_t;

  item_t sb[$];

  lcd_bus_writer #(
    .PWR_CYC   (P_PWR),
    .SETUP_CYC (P_SETUP),
    .EN_CYC    (P_EN),
    .HOLD_CYC  (P_HOLD),
    .EXEC_CYC  (P_EXEC),
    .LONG_CYC  (P_LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .busy      (busy),
    .lcd_dat   (lcd_dat),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: execution wait from the command rules, and the full accept-to-accept period
  // (the accept cycle itself counts as one).
  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) return P_LONG;
    return P_EXEC;
  endfunction

  function automatic int exp_period(input logic rs, input logic [7:0] d);
    return 1 + P_SETUP + P_EN + P_HOLD + exp_wait(rs, d);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pairs each enable pulse with the oldest logged accept and times the whole transfer.
  initial begin
    logic  prev_en  = 1'b0;
    logic  prev_rdy = 1'b0;
    logic  cur_v    = 1'b0;
    int    width    = 0;
    item_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en  = 1'b0;
        prev_rdy = 1'b0;
        cur_v    = 1'b0;
        width    = 0;
      end else begin
        check("busy_inv", busy, !req_ready);
        check("rw_low", lcd_rw, 0);
        if (lcd_en && !prev_en) begin
          check("en_has_request", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur   = sb.pop_front();
            cur_v = 1'b1;
            check("en_start", cyc + 1 - cur.acc, 1 + P_SETUP);
          end
          width = 0;
        end
        if (lcd_en) begin
          width++;
          if (cur_v) begin
            check("pulse_dat", lcd_dat, cur.dat);
            check("pulse_rs", lcd_rs, cur.rs);
          end
        end
        if (!lcd_en && prev_en) check("en_width", width, P_EN);
        if (req_ready && !prev_rdy && cur_v) begin
          check("ready_latency", cyc + 1 - cur.acc, exp_period(cur.rs, cur.dat));
          cur_v = 1'b0;
        end
        prev_en  = lcd_en;
        prev_rdy = req_ready;
      end
    end
  end

  // Present a request and log it at the edge where it is taken; returns just after that edge.
  task automatic issue(input logic rs, input logic [7:0] d, input bit chk_gap, input int gap);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (req_ready) begin
        item_t it;
        it.rs  = rs;
        it.dat = d;
        it.acc = cyc + 1;
        sb.push_back(it);
        if (chk_gap) check("accept_gap", it.acc - last_acc, gap);
        last_acc = it.acc;
        done     = 1'b1;
      end
    end
    check("accepted", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      #1;
      ok = req_ready && (sb.size() == 0);
    end
    check("drain", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, lcd_en, 0);
    check({tag, "_rs"}, lcd_rs, 0);
    check({tag, "_dat"}, lcd_dat, 0);
    check({tag, "_rw"}, lcd_rw, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic release_and_check(input string tag);
    int r;
    int lat   = -1;
    int en_hi = 0;
    bit seen  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (lcd_en) en_hi++;
      if (req_ready) begin
        seen = 1'b1;
        lat  = cyc - r;
      end
    end
    check({tag, "_ready_after_release"}, lat, P_PWR);
    check({tag, "_en_quiet"}, en_hi, 0);
  endtask

  initial begin
    logic [7:0] seq_dat [7];
    logic       seq_rs  [7];
    seq_dat = '{8'h38, 8'h0C, 8'h06, 8'h46, 8'h50, 8'h47, 8'h41};
    seq_rs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_check("pwrup");

    issue(1'b1, 8'h48, 1'b0, 0);
    req_valid = 1'b0;
    wait_idle();

    // Long-wait boundary: only commands 01..03 stretch the wait.
    issue(1'b0, 8'h01, 1'b0, 0); req_valid = 1'b0; wait_idle();
    issue(1'b1, 8'h01, 1'b0, 0); req_valid = 1'b0; wait_idle();
    issue(1'b0, 8'h03, 1'b0, 0); req_valid = 1'b0; wait_idle();
    issue(1'b0, 8'h04, 1'b0, 0); req_valid = 1'b0; wait_idle();
    issue(1'b0, 8'h00, 1'b0, 0); req_valid = 1'b0; wait_idle();

    for (int i = 0; i < 7; i++) begin
      issue(seq_rs[i], seq_dat[i], i > 0,
            (i > 0) ? exp_period(seq_rs[i > 0 ? i - 1 : 0], seq_dat[i > 0 ? i - 1 : 0]) : 0);
    end
    req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      logic       rs;
      logic [7:0] d;
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(rs, d, 1'b0, 0);
      if ($urandom_range(0, 1) == 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    wait_idle();

    issue(1'b1, 8'h5A, 1'b0, 0);
    req_valid = 1'b0;
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
        @(negedge clk);
        hit = lcd_en;
      end
      check("reached_pulse", hit, 1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midpulse");
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("held_reset");
    release_and_check("repower");

    issue(1'b0, 8'h02, 1'b0, 0);
    req_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
